// File: rtl/sw_debounce.sv
// Board switch debouncer: 2-flop sync, shared tick prescaler,
// per-bit stability counters, registered edge pulses.
module sw_debounce #(
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 10
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] sw_raw_i,
   output logic [31:0] io_sw_o,
   output logic [31:0] sw_rise_o,
   output logic [31:0] sw_fall_o,
   output logic        sw_changed_o
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(STABLE_TICKS + 1);
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CLAST = CW'(STABLE_TICKS - 1);

   logic [31:0]   sync1_q;
   logic [31:0]   sync2_q;
   logic [31:0]   sw_q;
   logic [31:0]   sw_d;
   logic [31:0]   rise_q;
   logic [31:0]   rise_d;
   logic [31:0]   fall_q;
   logic [31:0]   fall_d;
   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;
   logic [CW-1:0] cnt_q [32];
   logic [CW-1:0] cnt_d [32];
   logic          tick;

   always_comb begin
      tick    = (presc_q == PLAST);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   // A bit commits only after STABLE_TICKS ticks of unbroken disagreement
   always_comb begin
      sw_d   = sw_q;
      rise_d = '0;
      fall_d = '0;
      cnt_d  = cnt_q;
      for (int b = 0; b < 32; b++) begin
         if (sync2_q[b] == sw_q[b]) begin
            cnt_d[b] = '0;
         end else if (tick) begin
            if (cnt_q[b] == CLAST) begin
               sw_d[b]   = sync2_q[b];
               rise_d[b] = sync2_q[b];
               fall_d[b] = ~sync2_q[b];
               cnt_d[b]  = '0;
            end else begin
               cnt_d[b] = cnt_q[b] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
         presc_q <= '0;
         sw_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         cnt_q   <= '{default: '0};
      end else begin
         sync1_q <= sw_raw_i;
         sync2_q <= sync1_q;
         presc_q <= presc_d;
         sw_q    <= sw_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign io_sw_o      = sw_q;
   assign sw_rise_o    = rise_q;
   assign sw_fall_o    = fall_q;
   assign sw_changed_o = |(rise_q | fall_q);

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: slow (4,3) and fast (1,1) instances against
// a tick-counting reference model, plus directed literal checks.
module tb_sw_debounce;

   logic        clk = 0;
   logic        rst_n = 0;
   logic [31:0] raw = '0;
   logic [31:0] raw_f = '0;
   logic [31:0] io, rise, fall;
   logic [31:0] io_f, rise_f, fall_f;
   logic        chg, chg_f;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sw_debounce #(.TICK_DIV(4), .STABLE_TICKS(3)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .sw_raw_i(raw),
      .io_sw_o(io), .sw_rise_o(rise), .sw_fall_o(fall),
      .sw_changed_o(chg)
   );

   sw_debounce #(.TICK_DIV(1), .STABLE_TICKS(1)) u_fast (
      .clk_i(clk), .rst_ni(rst_n), .sw_raw_i(raw_f),
      .io_sw_o(io_f), .sw_rise_o(rise_f), .sw_fall_o(fall_f),
      .sw_changed_o(chg_f)
   );

   // Reference model: edge index n since reset release; sync2 at edge n
   // is the raw word sampled at edge n-2; ticks are edges with
   // n%td==td-1; a bit commits once st ticks fall inside its current
   // run of disagreement.
   int          n [2];
   logic [31:0] r1 [2];
   logic [31:0] r2 [2];
   logic [31:0] deb [2];
   logic [31:0] mr [2];
   logic [31:0] mf [2];
   int          ds [2][32];

   task automatic m_step(input int k, input logic rn,
                         input logic [31:0] rw, input int td,
                         input int st);
      logic [31:0] nd;
      int t;
      if (!rn) begin
         n[k] = 0; r1[k] = '0; r2[k] = '0; deb[k] = '0;
         mr[k] = '0; mf[k] = '0;
         for (int b = 0; b < 32; b++) ds[k][b] = -1;
         return;
      end
      nd = deb[k]; mr[k] = '0; mf[k] = '0;
      for (int b = 0; b < 32; b++) begin
         if (r2[k][b] == deb[k][b]) begin
            ds[k][b] = -1;
         end else begin
            if (ds[k][b] < 0) ds[k][b] = n[k];
            t = (n[k] + 1) / td - ds[k][b] / td;
            if (t >= st) begin
               nd[b] = r2[k][b];
               if (r2[k][b]) mr[k][b] = 1'b1;
               else          mf[k][b] = 1'b1;
               ds[k][b] = -1;
            end
         end
      end
      deb[k] = nd;
      r2[k] = r1[k];
      r1[k] = rw;
      n[k]++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_rng(input string nm, input int act,
                          input int lo, input int hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   always @(posedge clk) begin
      m_step(0, rst_n, raw, 4, 3);
      m_step(1, rst_n, raw_f, 1, 1);
      #1;
      chk("slow io_sw", io, deb[0]);
      chk("slow rise", rise, mr[0]);
      chk("slow fall", fall, mf[0]);
      chk("slow changed", 32'(chg), 32'(|(mr[0] | mf[0])));
      chk("fast io_sw", io_f, deb[1]);
      chk("fast rise", rise_f, mr[1]);
      chk("fast fall", fall_f, mf[1]);
      chk("fast changed", 32'(chg_f), 32'(|(mr[1] | mf[1])));
   end

   // Waits for io to move; e = edges taken, -1 on timeout
   task automatic wait_change(input int maxe, output int e,
                              output logic [31:0] i0,
                              output logic [31:0] rr,
                              output logic [31:0] ff,
                              output logic c0);
      logic [31:0] st;
      st = io;
      e = -1; i0 = io; rr = '0; ff = '0; c0 = 1'b0;
      for (int i = 1; i <= maxe; i++) begin
         @(posedge clk); #2;
         if (io != st) begin
            e = i; i0 = io; rr = rise; ff = fall; c0 = chg;
            return;
         end
      end
   endtask

   initial begin
      int e;
      logic [31:0] i0, rr, ff;
      logic c0, rn;

      for (int b = 0; b < 32; b++) begin
         ds[0][b] = -1; ds[1][b] = -1;
      end

      // reset with all switches high
      raw = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      #1;
      chk("rst io_sw", io, 32'h0);
      chk("rst rise", rise, 32'h0);
      chk("rst changed", 32'(chg), 32'h0);
      @(negedge clk); rst_n = 1;
      wait_change(20, e, i0, rr, ff, c0);
      chk_rng("rst commit edges", e, 11, 14);
      chk("rst commit io", i0, 32'hFFFF_FFFF);
      chk("rst commit rise", rr, 32'hFFFF_FFFF);
      chk("rst commit changed", 32'(c0), 32'h1);
      @(posedge clk); #2;
      chk("rst rise one cycle", rise, 32'h0);

      @(negedge clk); raw = '0;
      wait_change(20, e, i0, rr, ff, c0);
      chk("all fall", ff, 32'hFFFF_FFFF);
      repeat (3) @(negedge clk);

      // bounce on bit 0
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk("bounce rise0", 32'(rise[0]), 32'h0);
         if (i % 3 == 0) raw[0] = ~raw[0];
      end
      @(negedge clk);
      chk("bounce io", io, 32'h0);
      raw[0] = 1'b1;
      wait_change(20, e, i0, rr, ff, c0);
      chk_rng("bounce commit edges", e, 11, 14);
      chk("bounce rise", rr, 32'h1);

      // simultaneous set bit 3 / clear bit 7
      @(negedge clk); raw = 32'h80;
      wait_change(20, e, i0, rr, ff, c0);
      chk("pre sim io", i0, 32'h80);
      @(negedge clk); raw = 32'h08;
      wait_change(20, e, i0, rr, ff, c0);
      chk("sim io", i0, 32'h08);
      chk("sim rise", rr, 32'h08);
      chk("sim fall", ff, 32'h80);
      chk("sim changed", 32'(c0), 32'h1);
      @(negedge clk); raw = '0;
      wait_change(20, e, i0, rr, ff, c0);
      chk("clear io", i0, 32'h0);

      // reset mid-count
      @(negedge clk); raw = 32'h20;
      repeat (8) @(negedge clk);
      rst_n = 0;
      @(negedge clk); rst_n = 1;
      wait_change(20, e, i0, rr, ff, c0);
      chk_rng("midrst commit edges", e, 11, 14);
      chk("midrst io", i0, 32'h20);
      chk("midrst rise", rr, 32'h20);

      // fast config: follow in exactly 3 edges
      @(negedge clk); raw_f = 32'h8000_0000;
      @(posedge clk);
      @(posedge clk); #2;
      chk("fast e2 io", io_f, 32'h0);
      @(posedge clk); #2;
      chk("fast e3 io", io_f, 32'h8000_0000);
      chk("fast e3 rise", rise_f, 32'h8000_0000);
      repeat (2) @(negedge clk);
      raw_f = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("fast fall io", io_f, 32'h0);
      chk("fast fall", fall_f, 32'h8000_0000);
      repeat (2) @(negedge clk);
      raw_f = 32'h8000_0000;
      @(negedge clk); raw_f = '0;
      @(posedge clk);
      @(posedge clk); #2;
      chk("glitch rise", rise_f, 32'h8000_0000);
      @(posedge clk); #2;
      chk("glitch fall", fall_f, 32'h8000_0000);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         raw ^= $urandom & $urandom & $urandom & $urandom & $urandom;
         raw_f ^= $urandom & $urandom;
         rn = ($urandom_range(0, 399) != 0);
         rst_n = rn;
      end
      @(negedge clk); rst_n = 1;
      repeat (20) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
